saadi_op_sequencer: RTL and testbench



---
 rtl/saadi_pkg.sv | 14 +
 rtl/saadi_lfsr.sv | 21 ++
 rtl/saadi_op_sequencer.sv | 112 +++++++++++
 tb/tb_saadi_op_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/saadi_pkg.sv
// saadi_pkg: shared FSM encoding, width default, t clamp helper and LFSR taps for the SAADI operand sequencer
package saadi_pkg;
   localparam int N_DEF = 8;
   localparam logic [7:0] LFSR_TAPS_8 = 8'b1011_1000;
   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      HOLD,
      DONE
   } state_e;
   function automatic int unsigned clamp_t(input int unsigned v, input int unsigned n);
      return v == 0 ? 1 : v >= n ? n - 1 : v;
   endfunction
endpackage

// File: rtl/saadi_lfsr.sv
// saadi_lfsr: N-bit Fibonacci LFSR with synchronous seed load and single-step enable; nxt is the state one step ahead
module saadi_lfsr
   import saadi_pkg::*;
#(
   parameter int N = N_DEF,
   parameter logic [N-1:0] TAPS = N'(LFSR_TAPS_8)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         step,
   input  logic [N-1:0] seed,
   output logic [N-1:0] nxt
);
   logic [N-1:0] lfsr_q, lfsr_d;
   assign nxt = {lfsr_q[N-2:0], ^(lfsr_q & TAPS)};
   // Seed load wins over stepping so a new sweep always restarts the sequence
   always_comb lfsr_d = load ? seed : step ? nxt : lfsr_q;
   // LFSR state register
   always_ff @(posedge clk) lfsr_q <= rst ? '0 : lfsr_d;
endmodule

// File: rtl/saadi_op_sequencer.sv
// saadi_op_sequencer: sweeps (A,B) operand pairs over a rectangle with valid/ready issue and fixed dwell; SAADI_SEQ_LFSR_EN selects LFSR ordering
module saadi_op_sequencer
   import saadi_pkg::*;
#(
   parameter int N        = N_DEF,
   parameter int HOLD_CYC = 7,
   parameter int A_START  = 1,
   parameter int A_END    = 255,
   parameter int B_START  = 1,
   parameter int B_END    = 255
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [N-1:0]   t_in,
   input  logic           op_ready,
   output logic [N-1:0]   A,
   output logic [N-1:0]   B,
   output logic [N-1:0]   t,
   output logic           op_valid,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] pair_cnt
);
   localparam int PW = 2 * N;
   localparam int CW = HOLD_CYC > 1 ? $clog2(HOLD_CYC) : 1;
   localparam logic [N-1:0] AS = N'(A_START);
   localparam logic [N-1:0] AE = N'(A_END);
   localparam logic [N-1:0] BS = N'(B_START);
   localparam logic [N-1:0] BE = N'(B_END);
   state_e state_q, state_d;
   logic [N-1:0] a_q, a_d, b_q, b_d, t_q, t_d, a_nx, b_nx;
   logic [PW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] dw_q, dw_d;
   logic adv, last;
`ifdef SAADI_SEQ_LFSR_EN
   localparam logic [PW-1:0] TOTAL = PW'((A_END - A_START + 1) * (B_END - B_START + 1));
   logic [N-1:0] la_nxt, lb_nxt;
   logic lfsr_ld, lfsr_st;
   assign lfsr_ld = state_q == IDLE && start;
   assign lfsr_st = adv && !last;
   saadi_lfsr #(.N(N)) u_lfsr_a (.clk(clk), .rst(reset), .load(lfsr_ld), .step(lfsr_st), .seed(AS), .nxt(la_nxt));
   saadi_lfsr #(.N(N)) u_lfsr_b (.clk(clk), .rst(reset), .load(lfsr_ld), .step(lfsr_st), .seed(BS), .nxt(lb_nxt));
   assign last = (state_q == ISSUE ? cnt_q + PW'(1) : cnt_q) == TOTAL;
   assign a_nx = la_nxt >= AS && la_nxt <= AE ? la_nxt : AS;
   assign b_nx = lb_nxt >= BS && lb_nxt <= BE ? lb_nxt : BS;
`else
   assign last = a_q == AE && b_q == BE;
   assign a_nx = b_q == BE ? a_q + N'(1) : a_q;
   assign b_nx = b_q == BE ? BS : b_q + N'(1);
`endif
   // Sweep FSM: next state, operand advance, pair counter and dwell countdown
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      t_d     = t_q;
      cnt_d   = cnt_q;
      dw_d    = dw_q;
      adv     = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            state_d = ISSUE;
            t_d     = N'(clamp_t(32'(t_in), N));
            a_d     = AS;
            b_d     = BS;
            cnt_d   = '0;
         end
         ISSUE: if (op_ready) begin
            state_d = HOLD;
            cnt_d   = cnt_q + PW'(1);
            dw_d    = CW'(HOLD_CYC - 1);
            adv     = HOLD_CYC == 1;
         end
         HOLD: begin
            dw_d = dw_q - CW'(1);
            adv  = dw_q == CW'(1);
         end
         default: state_d = IDLE;
      endcase
      if (adv) begin
         state_d = last ? DONE : ISSUE;
         a_d     = last ? a_q : a_nx;
         b_d     = last ? b_q : b_nx;
      end
   end
   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         t_q     <= '0;
         cnt_q   <= '0;
         dw_q    <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         t_q     <= t_d;
         cnt_q   <= cnt_d;
         dw_q    <= dw_d;
      end
   end
   assign A        = a_q;
   assign B        = b_q;
   assign t        = t_q;
   assign pair_cnt = cnt_q;
   assign op_valid = state_q == ISSUE;
   assign busy     = state_q == ISSUE || state_q == HOLD;
   assign done     = state_q == DONE;
endmodule

// File: tb/tb_saadi_op_sequencer.sv
// tb_saadi_op_sequencer: self-checking bench with a small 2x3 sweep (dwell 7) and a full default 255x255 sweep (dwell 1)
module tb_saadi_op_sequencer;
   typedef struct {
      logic [7:0] t_in;
      logic [7:0] t_exp;
   } tvec_t;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_s = 1'b1, start_s = 1'b0, rdy_s = 1'b0;
   logic [7:0] tin_s = '0, a_s, b_s, t_s;
   logic v_s, busy_s, done_s;
   logic [15:0] cnt_s;
   logic rst_f = 1'b1, start_f = 1'b0, rdy_f = 1'b0;
   logic [7:0] tin_f = '0, a_f, b_f, t_f;
   logic v_f, busy_f, done_f;
   logic [15:0] cnt_f;
   saadi_op_sequencer #(.N(8), .HOLD_CYC(7), .A_START(1), .A_END(2), .B_START(1), .B_END(3)) dut_s (
      .clk(clk), .reset(rst_s), .start(start_s), .t_in(tin_s), .op_ready(rdy_s),
      .A(a_s), .B(b_s), .t(t_s), .op_valid(v_s), .busy(busy_s), .done(done_s), .pair_cnt(cnt_s));
   saadi_op_sequencer #(.HOLD_CYC(1)) dut_f (
      .clk(clk), .reset(rst_f), .start(start_f), .t_in(tin_f), .op_ready(rdy_f),
      .A(a_f), .B(b_f), .t(t_f), .op_valid(v_f), .busy(busy_f), .done(done_f), .pair_cnt(cnt_f));
   int checks = 0;
   int failures = 0;
   logic [15:0] expq[$];
   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
`ifdef SAADI_SEQ_LFSR_EN
   function automatic int lfsr_next(input int x);
      return ((x << 1) & 255) | (((x >> 7) ^ (x >> 5) ^ (x >> 4) ^ (x >> 3)) & 1);
   endfunction
`endif
   // Expected pair order for a rectangle, {A,B} per entry
   task automatic build(input int as, input int ae, input int bs, input int be);
      int total;
`ifdef SAADI_SEQ_LFSR_EN
      int la, lb;
      la = as;
      lb = bs;
`endif
      total = (ae - as + 1) * (be - bs + 1);
      expq.delete();
      for (int k = 0; k < total; k++) begin
`ifdef SAADI_SEQ_LFSR_EN
         expq.push_back({8'((la >= as && la <= ae) ? la : as), 8'((lb >= bs && lb <= be) ? lb : bs)});
         la = lfsr_next(la);
         lb = lfsr_next(lb);
`else
         expq.push_back({8'(as + k / (be - bs + 1)), 8'(bs + k % (be - bs + 1))});
`endif
      end
   endtask
   initial begin
      tvec_t tv[7];
      logic [15:0] e;
      logic [7:0] et;
      int k, n, bad, dones, zeros, acc_c;
      bit prev_v, have_acc, got_done;
      tv[0] = '{8'd0, 8'd1};
      tv[1] = '{8'd9, 8'd7};
      tv[2] = '{8'd4, 8'd4};
      tv[3] = '{8'd8, 8'd7};
      tv[4] = '{8'd7, 8'd7};
      tv[5] = '{8'd1, 8'd1};
      tv[6] = '{8'd255, 8'd7};
      tick();
      tick();
      chk("rst_A", a_s, 0);
      chk("rst_B", b_s, 0);
      chk("rst_t", t_s, 0);
      chk("rst_valid", v_s, 0);
      chk("rst_busy", busy_s, 0);
      chk("rst_done", done_s, 0);
      chk("rst_cnt", cnt_s, 0);
      chk("rst_f_valid", v_f, 0);
      chk("rst_f_cnt", cnt_f, 0);
      rst_s = 1'b0;
      rst_f = 1'b0;
      build(1, 2, 1, 3);
      for (int i = 0; i < 7; i++) begin
         tin_s = tv[i].t_in;
         start_s = 1'b1;
         tick();
         start_s = 1'b0;
         e = expq[0];
         chk("tbl_t", t_s, tv[i].t_exp);
         chk("tbl_valid", v_s, 1);
         chk("tbl_busy", busy_s, 1);
         chk("tbl_A", a_s, e[15:8]);
         chk("tbl_B", b_s, e[7:0]);
         chk("tbl_cnt", cnt_s, 0);
         rst_s = 1'b1;
         tick();
         rst_s = 1'b0;
         chk("tbl_rst_t", t_s, 0);
         chk("tbl_rst_valid", v_s, 0);
         chk("tbl_rst_busy", busy_s, 0);
      end
      rdy_s = 1'b1;
      tin_s = 8'd4;
      start_s = 1'b1;
      tick();
      start_s = 1'b0;
      k = 0;
      while (!(busy_s && !v_s && a_s == 8'd2) && k < 200) begin
         tick();
         k++;
      end
      chk("hold_a2_reached", k < 200, 1);
      rst_s = 1'b1;
      tick();
      rst_s = 1'b0;
      chk("midrst_A", a_s, 0);
      chk("midrst_B", b_s, 0);
      chk("midrst_t", t_s, 0);
      chk("midrst_cnt", cnt_s, 0);
      chk("midrst_valid", v_s, 0);
      chk("midrst_busy", busy_s, 0);
      chk("midrst_done", done_s, 0);
      dones = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         dones += int'(done_s);
      end
      chk("midrst_no_done", dones, 0);
      chk("midrst_idle", busy_s, 0);
      tin_s = 8'd3;
      start_s = 1'b1;
      tick();
      start_s = 1'b0;
      for (int c = 1; c <= 50; c++) begin
         k = (c - 1) / 7 > 5 ? 5 : (c - 1) / 7;
         e = expq[k];
         chk("seq_valid", v_s, c <= 36 && (c - 1) % 7 == 0);
         chk("seq_A", a_s, e[15:8]);
         chk("seq_B", b_s, e[7:0]);
         chk("seq_cnt", cnt_s, (c + 5) / 7 > 6 ? 6 : (c + 5) / 7);
         chk("seq_busy", busy_s, c <= 42);
         chk("seq_done", done_s, c == 43);
         chk("seq_t", t_s, 3);
         start_s = c == 5 || c == 20 || c == 43;
         tick();
      end
      start_s = 1'b1;
      tick();
      start_s = 1'b0;
      e = expq[1];
      for (int c = 1; c <= 15; c++) begin
         rdy_s = !(c >= 8 && c <= 12);
         if (c >= 8 && c <= 13) begin
            chk("bp_valid", v_s, 1);
            chk("bp_A", a_s, e[15:8]);
            chk("bp_B", b_s, e[7:0]);
            chk("bp_cnt", cnt_s, 1);
         end
         if (c == 14) begin
            chk("bp_cnt_after", cnt_s, 2);
            chk("bp_valid_after", v_s, 0);
         end
         tick();
      end
      rst_s = 1'b1;
      tick();
      rst_s = 1'b0;
      for (int s = 0; s < 20; s++) begin
         tin_s = 8'($urandom_range(0, 255));
         et = 8'(tin_s == 0 ? 1 : tin_s >= 8 ? 7 : int'(tin_s));
         rdy_s = 1'b0;
         start_s = 1'b1;
         tick();
         start_s = 1'b0;
         n = 0;
         acc_c = 0;
         have_acc = 0;
         prev_v = 0;
         got_done = 0;
         for (int c = 1; c <= 3000 && !got_done; c++) begin
            rdy_s = $urandom_range(0, 2) != 0;
            start_s = busy_s && $urandom_range(0, 7) == 0;
            chk("rnd_cnt", cnt_s, n);
            chk("rnd_t", t_s, et);
            if (v_s) begin
               chk("rnd_pair_in_range", n < 6, 1);
               if (n < 6) begin
                  e = expq[n];
                  chk("rnd_A", a_s, e[15:8]);
                  chk("rnd_B", b_s, e[7:0]);
               end
            end
            if (v_s && !prev_v && have_acc) chk("rnd_dwell", c - acc_c, 7);
            if (done_s) begin
               chk("rnd_dwell_done", c - acc_c, 7);
               chk("rnd_pairs", n, 6);
               got_done = 1;
            end
            if (v_s && rdy_s) begin
               n++;
               acc_c = c;
               have_acc = 1;
            end
            prev_v = v_s;
            tick();
         end
         start_s = 1'b0;
         chk("rnd_finished", got_done, 1);
         chk("rnd_single_done", done_s, 0);
         chk("rnd_idle", busy_s, 0);
      end
      build(1, 255, 1, 255);
      tin_f = 8'd200;
      rdy_f = 1'b1;
      start_f = 1'b1;
      tick();
      start_f = 1'b0;
      bad = 0;
      dones = 0;
      zeros = 0;
      for (int c = 1; c <= 65030; c++) begin
         if (c <= 65025) begin
            e = expq[c - 1];
            if (!v_f || a_f != e[15:8] || b_f != e[7:0] || cnt_f != 16'(c - 1) || done_f) bad++;
         end
         dones += int'(done_f);
         zeros += int'(v_f && (a_f == 0 || b_f == 0));
         if (c == 65026) begin
            e = expq[65024];
            chk("full_done_cycle", done_f, 1);
            chk("full_cnt", cnt_f, 65025);
            chk("full_last_A", a_f, e[15:8]);
            chk("full_last_B", b_f, e[7:0]);
         end
         tick();
      end
      chk("full_seq_deviations", bad, 0);
      chk("full_done_pulses", dones, 1);
      chk("full_zero_operands", zeros, 0);
      chk("full_t", t_f, 7);
      chk("full_idle", busy_f, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
